// File: rtl/pc_ret_stack.sv
// pc_ret_stack: CALL/RET return-address stack with the next-PC source mux.
// The stack is a ring: base_q points at the oldest entry and the top sits at
// base_q + CNT - 1, so a push while full can drop the oldest entry in place.
// Optional feature macro: PC_RET_STACK_OVF_TRAP_EN. When it is defined, a push
// while full is dropped and flags ERR. When it is undefined, a push while full
// overwrites the oldest entry.
module pc_ret_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [AW-1:0]            PC_COUNT,
    input  logic [AW-1:0]            FROM_IMMED,
    input  logic [1:0]               PC_MUX_SEL,
    input  logic                     PUSH,
    input  logic                     POP,
    output logic [AW-1:0]            DIN,
    output logic [$clog2(DEPTH):0]   CNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          we;
    logic [PW-1:0] waddr;
    logic [PW-1:0] top_idx;
    logic [AW-1:0] ret_addr;
    logic          empty_w, full_w;

    assign empty_w  = (cnt_q == '0);
    assign full_w   = (cnt_q == CW'(DEPTH));
    // When full, the low PW bits of the count are zero, so this wraps to base_q - 1.
    assign top_idx  = base_q + cnt_q[PW-1:0] - PW'(1);
    assign ret_addr = PC_COUNT + AW'(1);

    assign CNT   = cnt_q;
    assign EMPTY = empty_w;
    assign FULL  = full_w;
    assign ERR   = err_q;

    // Next-state for count, ring base and fault flag; selects the entry to write.
    always_comb begin
        cnt_d  = cnt_q;
        base_d = base_q;
        err_d  = err_q;
        we     = 1'b0;
        waddr  = '0;
        if (PUSH && POP && !empty_w) begin
            we    = 1'b1;
            waddr = top_idx;
        end else if (PUSH) begin
            if (!full_w) begin
                we    = 1'b1;
                waddr = base_q + cnt_q[PW-1:0];
                cnt_d = cnt_q + CW'(1);
            end else begin
`ifdef PC_RET_STACK_OVF_TRAP_EN
                err_d = 1'b1;
`else
                // The oldest slot receives the new top; advancing base retires the oldest entry.
                we     = 1'b1;
                waddr  = base_q;
                base_d = base_q + PW'(1);
`endif
            end
        end else if (POP) begin
            if (empty_w) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            base_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
            err_q  <= err_d;
        end
    end

    // Entry storage is not reset; writes are suppressed on edges seen while in reset.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            mem_q[waddr] <= ret_addr;
        end
    end

    // Next-PC source mux; an empty stack reads as zero.
    always_comb begin
        DIN = '0;
        case (PC_MUX_SEL)
            2'b00:   DIN = FROM_IMMED;
            2'b01:   DIN = empty_w ? '0 : mem_q[top_idx];
            2'b10:   DIN = '1;
            default: DIN = '0;
        endcase
    end

endmodule

// File: tb/tb_pc_ret_stack.sv
// tb_pc_ret_stack: directed bench for pc_ret_stack (DEPTH=8, AW=10).
// Expected values come from a queue-based stack model held by the bench.
module tb_pc_ret_stack;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] PC_COUNT;
    logic [9:0] FROM_IMMED;
    logic [1:0] PC_MUX_SEL;
    logic       PUSH;
    logic       POP;
    logic [9:0] DIN;
    logic [3:0] CNT;
    logic       EMPTY;
    logic       FULL;
    logic       ERR;

    pc_ret_stack #(.DEPTH(8), .AW(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_COUNT   (PC_COUNT),
        .FROM_IMMED (FROM_IMMED),
        .PC_MUX_SEL (PC_MUX_SEL),
        .PUSH       (PUSH),
        .POP        (POP),
        .DIN        (DIN),
        .CNT        (CNT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_exp[$];
    string       sb_tag[$];

    logic [9:0]  stk[$];
    logic        m_err = 1'b0;

    task automatic expect_v(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic observe(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        if (sb_exp.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow observed %h expected none", obs);
        end else begin
            exp = sb_exp.pop_front();
            tag = sb_tag.pop_front();
            checks++;
            assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_v(tag, exp);
        observe(obs);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cnt"},   32'(CNT),   32'(stk.size()));
        chk({tag, "_empty"}, 32'(EMPTY), 32'(stk.size() == 0));
        chk({tag, "_full"},  32'(FULL),  32'(stk.size() == 8));
        chk({tag, "_err"},   32'(ERR),   32'(m_err));
    endtask

    // One clocked operation, called #1 after a rising edge; updates the model.
    task automatic op(input logic push, input logic pop, input logic [9:0] pc);
        logic       check_din;
        logic [9:0] nv;
        PUSH       = push;
        POP        = pop;
        PC_COUNT   = pc;
        PC_MUX_SEL = 2'b01;
        nv         = pc + 10'd1;
        check_din  = pop && !push;
        if (check_din) expect_v("pop_din", 32'(stk.size() == 0 ? 10'h000 : stk[stk.size()-1]));
        if (push && pop && stk.size() != 0) begin
            stk[stk.size()-1] = nv;
        end else if (push) begin
            if (stk.size() < 8) begin
                stk.push_back(nv);
            end else begin
`ifdef PC_RET_STACK_OVF_TRAP_EN
                m_err = 1'b1;
`else
                void'(stk.pop_front());
                stk.push_back(nv);
`endif
            end
        end else if (pop) begin
            if (stk.size() == 0) m_err = 1'b1;
            else void'(stk.pop_back());
        end
        #1;
        if (check_din) observe(32'(DIN));
        @(posedge CLK);
        #1;
        PUSH = 1'b0;
        POP  = 1'b0;
    endtask

    task automatic chk_top(input string tag, input logic [9:0] exp);
        PC_MUX_SEL = 2'b01;
        #1;
        chk(tag, 32'(DIN), 32'(exp));
    endtask

    initial begin
        // Reset with PUSH/POP active across two edges: both must be ignored.
        RST        = 1'b1;
        PUSH       = 1'b1;
        POP        = 1'b1;
        PC_COUNT   = 10'h0AA;
        FROM_IMMED = 10'h000;
        PC_MUX_SEL = 2'b01;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        PUSH = 1'b0;
        POP  = 1'b0;
        chk_top("reset_din", 10'h000);
        chk_state("reset");

        // Two calls then two returns.
        op(1'b1, 1'b0, 10'h045);
        op(1'b1, 1'b0, 10'h120);
        chk_state("two_push");
        op(1'b0, 1'b1, 10'h000);
        op(1'b0, 1'b1, 10'h000);
        chk_state("two_pop");

        // PC wrap on push, then same-cycle push+pop replaces the top.
        op(1'b1, 1'b0, 10'h3FF);
        chk_top("wrap_top", 10'h000);
        chk_state("wrap");
        op(1'b1, 1'b1, 10'h010);
        chk_top("pushpop_top", 10'h011);
        chk_state("pushpop");
        op(1'b0, 1'b1, 10'h000);
        chk_state("drain1");

        // Push+pop while empty acts as a plain push.
        op(1'b1, 1'b1, 10'h1F0);
        chk_top("pp_empty_top", 10'h1F1);
        chk_state("pp_empty");
        op(1'b1, 1'b0, 10'h055);

        // Mux sources other than the stack; no state change.
        FROM_IMMED = 10'h2AB;
        PC_MUX_SEL = 2'b00;
        #1 chk("sel00", 32'(DIN), 32'h2AB);
        PC_MUX_SEL = 2'b10;
        #1 chk("sel10", 32'(DIN), 32'h3FF);
        PC_MUX_SEL = 2'b11;
        #1 chk("sel11", 32'(DIN), 32'h000);
        @(posedge CLK);
        #1;
        chk_state("sel_nochange");
        chk_top("sel_top", 10'h056);
        op(1'b0, 1'b1, 10'h000);
        op(1'b0, 1'b1, 10'h000);
        chk_state("drain2");

        // Fill past capacity with PC 1..9, then drain through the model.
        for (int i = 1; i <= 9; i++) begin
            op(1'b1, 1'b0, 10'(i));
            if (i == 8) chk_state("full8");
        end
        chk_state("overflow");
`ifdef PC_RET_STACK_OVF_TRAP_EN
        chk_top("overflow_top", 10'h009);
`else
        chk_top("overflow_top", 10'h00A);
`endif
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, 10'h000);
        end
        chk_state("drained");

        // Underflow sets the sticky fault.
        op(1'b0, 1'b1, 10'h000);
        chk_state("underflow");
        op(1'b1, 1'b0, 10'h0F0);
        chk_state("sticky");

        // Asynchronous reset between edges clears state immediately.
        #3 RST = 1'b1;
        stk.delete();
        m_err = 1'b0;
        #1;
        chk_state("async_rst");
        PUSH = 1'b1;
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        PUSH = 1'b0;
        chk_state("post_rst");
        chk_top("post_rst_din", 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
